conv_window_5x5: RTL and testbench

CONV_WINDOW_5X5 -- requirements
Module: conv_window_5x5

---
 rtl/conv_window_5x5.sv | 138 +++++++++++++
 tb/tb_conv_window_5x5.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_5x5.sv
// 5x5 sliding-window generator over a raster pixel stream, built from four chained line buffers.
// Optional frame-done pulse is enabled with `define CONV_WIN_FRAME_DONE_EN.

module conv_win_linebuf #(
  parameter int D  = 16,
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [D-1:0]  wdata_i,
  output logic [D-1:0]  rdata_o
);
  // Read-before-write at the same column: the old pixel moves to the next
  // line buffer while the new one replaces it.
  logic [D-1:0] mem_q [W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

module conv_window_5x5 #(
  parameter int D = 16,
  parameter int W = 32,
  parameter int H = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_sof,
  input  logic [D-1:0]    i_data,
  output logic            o_valid,
  output logic [25*D-1:0] o_win
`ifdef CONV_WIN_FRAME_DONE_EN
  ,
  output logic            o_frame_done
`endif
);
  localparam int AW = $clog2(W);
  localparam int RW = $clog2(H);

  logic [AW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          last_col, last_row, win_ok;

  logic [D-1:0]  lb_rd [4];
  logic [D-1:0]  lb_wr [4];
  logic [4:0][D-1:0]      col_pix;
  logic [4:0][4:0][D-1:0] win_q, win_d, out_q;
  logic          vld_q;

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  always_comb begin
    cur_col  = col_q;
    cur_row  = row_q;
    if (i_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
    last_col = (cur_col == AW'(W - 1));
    last_row = (cur_row == RW'(H - 1));
    win_ok   = i_valid && (cur_row >= RW'(4)) && (cur_col >= AW'(4));

    col_d = col_q;
    row_d = row_q;
    if (i_valid) begin
      col_d = last_col ? '0 : cur_col + 1'b1;
      if (last_col) row_d = last_row ? '0 : cur_row + 1'b1;
      else          row_d = cur_row;
    end
  end

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_lb
      if (k == 0) begin : g_head
        assign lb_wr[k] = i_data;
      end else begin : g_chain
        assign lb_wr[k] = lb_rd[k-1];
      end
      conv_win_linebuf #(.D(D), .W(W), .AW(AW)) u_lb (
        .clk_i   (i_clk),
        .we_i    (i_valid),
        .addr_i  (cur_col),
        .wdata_i (lb_wr[k]),
        .rdata_o (lb_rd[k])
      );
    end
  endgenerate

  // Row 4 of the window is the current row; line buffer k holds row-(k+1).
  always_comb begin
    col_pix    = '0;
    col_pix[4] = i_data;
    for (int j = 0; j < 4; j++) col_pix[3-j] = lb_rd[j];

    win_d = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][4] = col_pix[r];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      vld_q <= win_ok;
      if (i_valid) win_q <= win_d;
      // Output only moves on complete windows so it holds between them.
      if (win_ok)  out_q <= win_d;
    end
  end

  assign o_valid = vld_q;
  assign o_win   = out_q;

`ifdef CONV_WIN_FRAME_DONE_EN
  logic fd_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fd_q <= 1'b0;
    else          fd_q <= win_ok && last_row && last_col;
  end

  assign o_frame_done = fd_q;
`endif
endmodule

// File: tb/tb_conv_window_5x5.sv
// Bench for conv_window_5x5 (W=H=8, D=16): scenario table, corner-case sequences and a
// randomized run, all checked cycle by cycle against a full-image reference model.
module tb_conv_window_5x5;
  localparam int D = 16;
  localparam int W = 8;
  localparam int H = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid = 1'b0;
  logic            sof = 1'b0;
  logic [D-1:0]    data = '0;
  logic            o_valid;
  logic [25*D-1:0] o_win;
`ifdef CONV_WIN_FRAME_DONE_EN
  logic            o_frame_done;
`endif

  always #5 clk = ~clk;

  conv_window_5x5 #(.D(D), .W(W), .H(H)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_sof   (sof),
    .i_data  (data),
    .o_valid (o_valid),
    .o_win   (o_win)
`ifdef CONV_WIN_FRAME_DONE_EN
    ,
    .o_frame_done (o_frame_done)
`endif
  );

  int checks = 0;
  int passes = 0;

  // Reference model: the frame as a 2-D image plus the raster position of the next pixel.
  logic [D-1:0]    img [H][W];
  int              m_row, m_col;
  logic [25*D-1:0] m_hold;

  int              win_cnt, acc_cnt, fd_cnt, first_at;
  logic [25*D-1:0] seen [$];

  typedef struct {
    string name;
    int    tog;
    int    frames;
    int    exp_cnt;
    int    exp_at;
    int    w0;
    int    ctr;
    int    last;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [25*D-1:0] act, input logic [25*D-1:0] e);
    checks++;
    if (act === e) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, e);
  endtask

  function automatic int sl(input logic [25*D-1:0] w, input int i);
    return int'(w[D*i +: D]);
  endfunction

  task automatic clear_stats();
    win_cnt  = 0;
    acc_cnt  = 0;
    fd_cnt   = 0;
    first_at = -1;
    seen.delete();
  endtask

  task automatic step(input logic v, input logic s, input logic [D-1:0] d);
    logic exp_v, exp_fd;
    @(negedge clk);
    valid = v; sof = s; data = d;
    exp_v = 1'b0; exp_fd = 1'b0;
    if (v) begin
      acc_cnt++;
      if (s) begin m_row = 0; m_col = 0; end
      img[m_row][m_col] = d;
      if (m_row >= 4 && m_col >= 4) begin
        exp_v  = 1'b1;
        exp_fd = (m_row == H-1) && (m_col == W-1);
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            m_hold[D*(5*r+c) +: D] = img[m_row-4+r][m_col-4+c];
      end
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row++;
        if (m_row == H) m_row = 0;
      end
    end
    @(posedge clk); #1;
    check("o_valid", o_valid, exp_v);
    check("o_win", o_win, m_hold);
`ifdef CONV_WIN_FRAME_DONE_EN
    check("o_frame_done", o_frame_done, exp_fd);
    if (o_frame_done) fd_cnt++;
`endif
    if (o_valid) begin
      win_cnt++;
      seen.push_back(o_win);
      if (win_cnt == 1) first_at = acc_cnt;
    end
  endtask

  // Reset is released just after a rising edge so the next edge may accept a pixel.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; sof = 1'b0;
    m_row = 0; m_col = 0; m_hold = '0;
    #1;
    check("rst_async_valid", o_valid, 0);
    check("rst_async_win", o_win, 0);
`ifdef CONV_WIN_FRAME_DONE_EN
    check("rst_async_fd", o_frame_done, 0);
`endif
    repeat (n) @(posedge clk);
    #1;
    check("rst_hold_valid", o_valid, 0);
    check("rst_hold_win", o_win, 0);
    rst_n = 1'b1;
  endtask

  task automatic ramp(input int n, input logic sof_first, input int tog);
    for (int i = 0; i < n; i++) begin
      if (tog != 0) step(1'b0, 1'b0, '0);
      step(1'b1, sof_first && (i == 0), D'(i % (W*H)));
    end
  endtask

  initial begin
    vecs[0] = '{"gapless",    0, 1, 16, 37, 0, 18, 36};
    vecs[1] = '{"toggle",     1, 1, 16, 37, 0, 18, 36};
    vecs[2] = '{"two_frames", 0, 2, 32, 37, 0, 18, 36};

    for (int v = 0; v < 3; v++) begin
      do_reset(2);
      clear_stats();
      ramp(64 * vecs[v].frames, 1'b1, vecs[v].tog);
      step(1'b0, 1'b0, '0);
      check({vecs[v].name, "_count"}, win_cnt, vecs[v].exp_cnt);
      check({vecs[v].name, "_first_at"}, first_at, vecs[v].exp_at);
      if (seen.size() > 0) begin
        check({vecs[v].name, "_w0"}, sl(seen[0], 0), vecs[v].w0);
        check({vecs[v].name, "_center"}, sl(seen[0], 12), vecs[v].ctr);
        check({vecs[v].name, "_last"}, sl(seen[0], 24), vecs[v].last);
        check({vecs[v].name, "_final_last"}, sl(seen[seen.size()-1], 24), 63);
      end
      if (vecs[v].frames > 1 && seen.size() > 16) begin
        check("frame2_w0", sl(seen[16], 0), 0);
        check("frame2_last", sl(seen[16], 24), 36);
      end
`ifdef CONV_WIN_FRAME_DONE_EN
      check({vecs[v].name, "_fd_count"}, fd_cnt, vecs[v].frames);
`endif
    end

    // Restart with i_sof partway through a frame.
    do_reset(2);
    clear_stats();
    ramp(21, 1'b1, 0);
    ramp(64, 1'b1, 0);
    step(1'b0, 1'b0, '0);
    check("midsof_count", win_cnt, 16);
    check("midsof_first_at", first_at, 21 + 37);

    // i_sof without i_valid must not restart the frame.
    do_reset(2);
    clear_stats();
    for (int i = 0; i < 64; i++) begin
      if (i == 30) step(1'b0, 1'b1, 16'hdead);
      step(1'b1, i == 0, D'(i));
    end
    step(1'b0, 1'b0, '0);
    check("idle_sof_count", win_cnt, 16);

    // Reset in mid-frame, then a frame with no i_sof.
    do_reset(2);
    ramp(46, 1'b1, 0);
    do_reset(2);
    clear_stats();
    ramp(64, 1'b0, 0);
    step(1'b0, 1'b0, '0);
    check("rst_mid_count", win_cnt, 16);
    check("rst_mid_first_at", first_at, 37);
    if (seen.size() > 0) begin
      check("rst_mid_w0", sl(seen[0], 0), 0);
      check("rst_mid_center", sl(seen[0], 12), 18);
      check("rst_mid_last", sl(seen[0], 24), 36);
    end

    // Random data, random gaps and occasional i_sof, with or without i_valid.
    do_reset(1);
    clear_stats();
    for (int i = 0; i < 1500; i++) begin
      logic rv, rs;
      rv = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 149) == 0) || (i == 0);
      step(rv, rs, D'($urandom));
    end
    step(1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
